// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register/data widths and the
// writeback buffer entry layout.
package mips_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic                  regwrite;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small write-buffer FIFO for writeback results. Count disambiguates
// full from empty; pointers wrap modulo DEPTH (power of two). The
// entries view is presented in age order: index 0 is the head (oldest).
module wb_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  entry_t                     din,
    input  logic                       pop,
    output entry_t                     head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output entry_t [DEPTH-1:0]         entries
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Next-state for storage, pointers and occupancy count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // State registers; reset discards every buffered entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Age-ordered view of the storage plus status flags.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[i] = mem_q[rd_ptr_q + PTR_W'(i)];
        end
        head  = mem_q[rd_ptr_q];
        count = count_q;
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
    end

endmodule

// File: rtl/wb_writer.sv
// Writeback-side driver of the register file write port. Accepts MEM
// results over valid/ready, applies the memtoreg select before buffering,
// and issues one register write per clock from the buffer head.
// Optional operand bypass from buffered entries: define WB_BYPASS_EN.
module wb_writer
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic                     mem_regwrite,
    input  logic                     mem_memtoreg,
    input  logic [ADDR_W-1:0]        mem_rd,
    input  logic [DATA_W-1:0]        mem_aluresult,
    input  logic [DATA_W-1:0]        mem_readdata,
    input  logic                     wb_hold,
    output logic                     regwrite,
    output logic [ADDR_W-1:0]        rd,
    output logic [DATA_W-1:0]        writedata,
    output logic [$clog2(DEPTH):0]   pending,
    output logic [31:0]              commit_count,
    input  logic [ADDR_W-1:0]        rs,
    input  logic [ADDR_W-1:0]        rt,
    input  logic [DATA_W-1:0]        rf_a,
    input  logic [DATA_W-1:0]        rf_b,
    output logic [DATA_W-1:0]        fwd_a,
    output logic [DATA_W-1:0]        fwd_b
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Entry layout follows the module widths so non-default ADDR_W/DATA_W still work.
    typedef struct packed {
        logic              regwrite;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t               push_entry;
    entry_t               head;
    entry_t [DEPTH-1:0]   entries;
    logic [CNT_W-1:0]     count;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    logic [ADDR_W-1:0]    rd_q, rd_d;
    logic [DATA_W-1:0]    writedata_q, writedata_d;
    logic [31:0]          commit_count_q, commit_count_d;

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .din     (push_entry),
        .pop     (pop),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .entries (entries)
    );

    // Handshake, memtoreg select, head presentation and write-port hold values.
    always_comb begin
        mem_ready           = !full;
        push                = mem_valid && !full;
        pop                 = !empty && !wb_hold;
        push_entry.regwrite = mem_regwrite;
        push_entry.rd       = mem_rd;
        push_entry.data     = mem_memtoreg ? mem_readdata : mem_aluresult;

        regwrite    = pop && head.regwrite && (head.rd != ADDR_W'(ZERO_REG));
        rd_d        = pop ? head.rd   : rd_q;
        writedata_d = pop ? head.data : writedata_q;
        rd          = rd_d;
        writedata   = writedata_d;

        commit_count_d = commit_count_q + (regwrite ? 32'd1 : 32'd0);
        pending        = count;
        commit_count   = commit_count_q;
    end

    // Last-presented write address/data and the commit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q           <= '0;
            writedata_q    <= '0;
            commit_count_q <= '0;
        end else begin
            rd_q           <= rd_d;
            writedata_q    <= writedata_d;
            commit_count_q <= commit_count_d;
        end
    end

`ifdef WB_BYPASS_EN
    // Youngest qualifying buffered entry wins: scan oldest-to-youngest, last hit overrides.
    always_comb begin
        fwd_a = rf_a;
        fwd_b = rf_b;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && entries[i].regwrite &&
                (entries[i].rd != ADDR_W'(ZERO_REG))) begin
                if (entries[i].rd == rs) fwd_a = entries[i].data;
                if (entries[i].rd == rt) fwd_b = entries[i].data;
            end
        end
    end
`else
    logic bypass_unused;

    // Bypass disabled: operands pass straight through from the register file.
    always_comb begin
        fwd_a         = rf_a;
        fwd_b         = rf_b;
        bypass_unused = ^{rs, rt, entries};
    end
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Self-checking bench for wb_writer with a queue-based reference model.
module tb_wb_writer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_ready, mem_regwrite, mem_memtoreg;
    logic [4:0]  mem_rd;
    logic [31:0] mem_aluresult, mem_readdata;
    logic        wb_hold;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] writedata;
    logic [1:0]  pending;
    logic [31:0] commit_count;
    logic [4:0]  rs, rt;
    logic [31:0] rf_a, rf_b, fwd_a, fwd_b;

    always #5 clk = ~clk;

    wb_writer #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
        .mem_rd(mem_rd), .mem_aluresult(mem_aluresult), .mem_readdata(mem_readdata),
        .wb_hold(wb_hold), .regwrite(regwrite), .rd(rd), .writedata(writedata),
        .pending(pending), .commit_count(commit_count),
        .rs(rs), .rt(rt), .rf_a(rf_a), .rf_b(rf_b), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    // Reference model: in-order queue of buffered results.
    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] d;
    } ment_t;

    ment_t       q[$];
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    logic [31:0] m_commit;
    int          vectors = 0;
    int          errors  = 0;

    function automatic bit m_pop();
        return (q.size() > 0) && !wb_hold;
    endfunction

    function automatic bit m_wr();
        return m_pop() && q[0].rw && (q[0].rd != 5'd0);
    endfunction

    function automatic logic [4:0] m_rdv();
        return m_pop() ? q[0].rd : m_rd;
    endfunction

    function automatic logic [31:0] m_wdv();
        return m_pop() ? q[0].d : m_wd;
    endfunction

    function automatic bit m_ready();
        return q.size() < DEPTH;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] rf);
`ifdef WB_BYPASS_EN
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].rw && q[i].rd != 5'd0 && q[i].rd == a) return q[i].d;
        end
`endif
        return rf;
    endfunction

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] r,
                         input logic [31:0] alu, input logic [31:0] rdat, input logic hold);
        mem_valid = v; mem_regwrite = rw; mem_memtoreg = m2r; mem_rd = r;
        mem_aluresult = alu; mem_readdata = rdat; wb_hold = hold;
        #1;
    endtask

    // Advance one clock edge and update the model; returns at the next falling edge.
    task automatic tick();
        bit          do_pop, do_push, wr;
        logic [4:0]  nrd;
        logic [31:0] nwd;
        ment_t       e;
        do_pop  = m_pop();
        do_push = mem_valid && m_ready();
        wr      = m_wr();
        nrd     = m_rdv();
        nwd     = m_wdv();
        e.rw    = mem_regwrite;
        e.rd    = mem_rd;
        e.d     = mem_memtoreg ? mem_readdata : mem_aluresult;
        @(posedge clk);
        if (rst) begin
            q.delete(); m_rd = '0; m_wd = '0; m_commit = '0;
        end else begin
            if (wr) m_commit = m_commit + 32'd1;
            if (do_pop) begin
                m_rd = nrd; m_wd = nwd;
                void'(q.pop_front());
            end
            if (do_push) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        tick(); tick();
        vectors++; if (pending !== 2'd0) begin errors++; $display("FAIL reset_pending got=%0d exp=0", pending); end
        vectors++; if (regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got=%0b exp=0", regwrite); end
        vectors++; if (rd !== 5'd0 || writedata !== 32'd0) begin errors++; $display("FAIL reset_rd_wd got=%0d/%h exp=0/0", rd, writedata); end
        vectors++; if (commit_count !== 32'd0) begin errors++; $display("FAIL reset_commit got=%0d exp=0", commit_count); end
        rst = 1'b0;
        #1;
        vectors++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", mem_ready); end
    endtask

    task automatic test_alu_write();
        drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h11, 32'h99, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        vectors++; if (regwrite !== 1'b1 || rd !== 5'd3 || writedata !== 32'h11) begin
            errors++; $display("FAIL alu_present got=%0b/%0d/%h exp=1/3/00000011", regwrite, rd, writedata); end
        vectors++; if (pending !== 2'd1) begin errors++; $display("FAIL alu_pending got=%0d exp=1", pending); end
        tick();
        vectors++; if (commit_count !== 32'd1) begin errors++; $display("FAIL alu_commit got=%0d exp=1", commit_count); end
        vectors++; if (pending !== 2'd0 || regwrite !== 1'b0 || rd !== 5'd3) begin
            errors++; $display("FAIL alu_after got=%0d/%0b/%0d exp=0/0/3", pending, regwrite, rd); end
    endtask

    task automatic test_load_select();
        drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h5, 32'hDEADBEEF, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        vectors++; if (regwrite !== 1'b1 || rd !== 5'd7 || writedata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_present got=%0b/%0d/%h exp=1/7/deadbeef", regwrite, rd, writedata); end
        tick();
        vectors++; if (commit_count !== 32'd2) begin errors++; $display("FAIL load_commit got=%0d exp=2", commit_count); end
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'hFF, 32'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        vectors++; if (regwrite !== 1'b0 || pending !== 2'd1) begin
            errors++; $display("FAIL zero_present got=%0b/%0d exp=0/1", regwrite, pending); end
        tick();
        vectors++; if (pending !== 2'd0 || commit_count !== 32'd2) begin
            errors++; $display("FAIL zero_after got=%0d/%0d exp=0/2", pending, commit_count); end
    endtask

    task automatic test_hold_full();
        drive(1'b1, 1'b1, 1'b0, 5'd1, 32'h101, 32'd0, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd2, 32'h202, 32'd0, 1'b1);
        vectors++; if (regwrite !== 1'b0 || mem_ready !== 1'b1) begin
            errors++; $display("FAIL hold_first got=%0b/%0b exp=0/1", regwrite, mem_ready); end
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h303, 32'd0, 1'b1);
        vectors++; if (mem_ready !== 1'b0 || pending !== 2'd2) begin
            errors++; $display("FAIL hold_full got=%0b/%0d exp=0/2", mem_ready, pending); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        vectors++; if (pending !== 2'd2 || regwrite !== 1'b1 || rd !== 5'd1 || writedata !== 32'h101) begin
            errors++; $display("FAIL hold_release got=%0d/%0b/%0d/%h exp=2/1/1/00000101", pending, regwrite, rd, writedata); end
        tick();
        vectors++; if (mem_ready !== 1'b1 || regwrite !== 1'b1 || rd !== 5'd2 || writedata !== 32'h202) begin
            errors++; $display("FAIL hold_second got=%0b/%0b/%0d/%h exp=1/1/2/00000202", mem_ready, regwrite, rd, writedata); end
        tick();
        vectors++; if (pending !== 2'd0 || commit_count !== m_commit) begin
            errors++; $display("FAIL hold_drained got=%0d/%0d exp=0/%0d", pending, commit_count, m_commit); end
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 32'hA, 32'd0, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 32'hB, 32'd0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
        rs = 5'd5; rf_a = 32'd0; rt = 5'd6; rf_b = 32'h77;
        #1;
`ifdef WB_BYPASS_EN
        vectors++; if (fwd_a !== 32'hB) begin errors++; $display("FAIL bypass_a got=%h exp=0000000b", fwd_a); end
`else
        vectors++; if (fwd_a !== 32'h0) begin errors++; $display("FAIL bypass_a got=%h exp=00000000", fwd_a); end
`endif
        vectors++; if (fwd_b !== 32'h77) begin errors++; $display("FAIL bypass_b got=%h exp=00000077", fwd_b); end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h909, 32'd0, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd10, 32'hA0A, 32'd0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        vectors++; if (pending !== 2'd2 || regwrite !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got=%0d/%0b exp=2/1", pending, regwrite); end
        rst = 1'b1;
        #1;
        vectors++; if (pending !== 2'd0 || regwrite !== 1'b0 || commit_count !== 32'd0) begin
            errors++; $display("FAIL rstmid_async got=%0d/%0b/%0d exp=0/0/0", pending, regwrite, commit_count); end
        q.delete(); m_rd = '0; m_wd = '0; m_commit = '0;
        tick();
        rst = 1'b0;
        #1;
        tick();
        vectors++; if (pending !== 2'd0 || regwrite !== 1'b0 || commit_count !== 32'd0 || rd !== 5'd0) begin
            errors++; $display("FAIL rstmid_after got=%0d/%0b/%0d/%0d exp=0/0/0/0", pending, regwrite, commit_count, rd); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 6)), $urandom, $urandom, ($urandom_range(0, 9) < 3));
            rs = 5'($urandom_range(0, 6)); rt = 5'($urandom_range(0, 6));
            rf_a = $urandom; rf_b = $urandom;
            #1;
            vectors++; if (mem_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, mem_ready, m_ready()); end
            vectors++; if (pending !== 2'(q.size())) begin errors++; $display("FAIL rnd_pending n=%0d got=%0d exp=%0d", n, pending, q.size()); end
            vectors++; if (regwrite !== m_wr()) begin errors++; $display("FAIL rnd_regwrite n=%0d got=%0b exp=%0b", n, regwrite, m_wr()); end
            vectors++; if (rd !== m_rdv()) begin errors++; $display("FAIL rnd_rd n=%0d got=%0d exp=%0d", n, rd, m_rdv()); end
            vectors++; if (writedata !== m_wdv()) begin errors++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, writedata, m_wdv()); end
            vectors++; if (commit_count !== m_commit) begin errors++; $display("FAIL rnd_commit n=%0d got=%0d exp=%0d", n, commit_count, m_commit); end
            vectors++; if (fwd_a !== m_fwd(rs, rf_a)) begin errors++; $display("FAIL rnd_fwd_a n=%0d got=%h exp=%h", n, fwd_a, m_fwd(rs, rf_a)); end
            vectors++; if (fwd_b !== m_fwd(rt, rf_b)) begin errors++; $display("FAIL rnd_fwd_b n=%0d got=%h exp=%h", n, fwd_b, m_fwd(rt, rf_b)); end
            tick();
        end
    endtask

    initial begin
        rs = '0; rt = '0; rf_a = '0; rf_b = '0;
        m_rd = '0; m_wd = '0; m_commit = '0;
        test_reset();
        test_alu_write();
        test_load_select();
        test_zero_reg();
        test_hold_full();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
